// File: rtl/enc_sampler.sv
// enc_sampler: periodic coherent snapshot of encoder counters with
// a time-shared velocity subtractor and a req/ack register read port.
module enc_sampler #(
  parameter int NCH    = 4,
  parameter int PERIOD = 50000
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [NCH*32-1:0] enc_count,
  input  logic              sample_now,
  input  logic              rd_req,
  input  logic [3:0]        rd_addr,
  output logic              rd_ack,
  output logic [31:0]       rd_data,
  output logic              sample_valid,
  output logic              busy
);
  localparam int TW = $clog2(PERIOD);
  localparam int IW = (NCH > 1) ? $clog2(NCH) : 1;
  localparam logic [TW-1:0] TMAX  = TW'(PERIOD - 1);
  localparam logic [IW-1:0] ILAST = IW'(NCH - 1);

  typedef enum logic [1:0] {IDLE, SCAN, PUBLISH} state_t;

  state_t        state_q, state_d;
  logic [TW-1:0] timer_q, timer_d;
  logic [IW-1:0] idx_q, idx_d;
  logic [31:0]   snap_q [NCH];
  logic [31:0]   snap_d [NCH];
  logic [31:0]   prev_q [NCH];
  logic [31:0]   prev_d [NCH];
  logic [31:0]   vsh_q  [NCH];
  logic [31:0]   vsh_d  [NCH];
  logic [31:0]   pos_q  [NCH];
  logic [31:0]   pos_d  [NCH];
  logic [31:0]   vel_q  [NCH];
  logic [31:0]   vel_d  [NCH];
  logic [15:0]   seq_q, seq_d;
  logic          primed_q, primed_d;
  logic          overrun_q, overrun_d;
  logic          busy_q, busy_d;
  logic          valid_q, valid_d;
  logic          ack_q, ack_d;
  logic [31:0]   data_q, data_d;

  logic          tick, trig, ovr_evt, stat_rd;
  logic [31:0]   delta, rd_mux;

  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    snap_d    = snap_q;
    prev_d    = prev_q;
    vsh_d     = vsh_q;
    pos_d     = pos_q;
    vel_d     = vel_q;
    seq_d     = seq_q;
    primed_d  = primed_q;
    busy_d    = busy_q;
    valid_d   = 1'b0;

    tick    = (timer_q == TMAX);
    timer_d = tick ? '0 : timer_q + 1'b1;
    trig    = tick | sample_now;
    ovr_evt = trig && (state_q != IDLE);

    // the only subtractor; SCAN walks it across the channels
    delta = snap_q[idx_q] - prev_q[idx_q];

    unique case (state_q)
      IDLE: begin
        if (trig) begin
          for (int i = 0; i < NCH; i++)
            snap_d[i] = enc_count[32*i +: 32];
          idx_d   = '0;
          busy_d  = 1'b1;
          state_d = SCAN;
        end
      end
      SCAN: begin
        vsh_d[idx_q]  = primed_q ? delta : 32'd0;
        prev_d[idx_q] = snap_q[idx_q];
        idx_d         = idx_q + 1'b1;
        if (idx_q == ILAST)
          state_d = PUBLISH;
      end
      PUBLISH: begin
        pos_d    = snap_q;
        vel_d    = vsh_q;
        seq_d    = seq_q + 16'd1;
        primed_d = 1'b1;
        valid_d  = 1'b1;
        busy_d   = 1'b0;
        state_d  = IDLE;
      end
      default: begin
        busy_d  = 1'b0;
        state_d = IDLE;
      end
    endcase

    rd_mux = '0;
    for (int i = 0; i < NCH; i++) begin
      if (rd_addr == 4'(i))     rd_mux = pos_q[i];
      if (rd_addr == 4'(i + 8)) rd_mux = vel_q[i];
    end
    if (rd_addr == 4'hF)
      rd_mux = {overrun_q, busy_q, primed_q, 13'b0, seq_q};

    ack_d   = rd_req && !ack_q;
    data_d  = ack_d ? rd_mux : data_q;
    stat_rd = ack_d && (rd_addr == 4'hF);
    // a fresh overrun on the clearing edge must not be lost
    overrun_d = ovr_evt | (overrun_q & ~stat_rd);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      timer_q   <= '0;
      idx_q     <= '0;
      for (int i = 0; i < NCH; i++) begin
        snap_q[i] <= '0;
        prev_q[i] <= '0;
        vsh_q[i]  <= '0;
        pos_q[i]  <= '0;
        vel_q[i]  <= '0;
      end
      seq_q     <= '0;
      primed_q  <= 1'b0;
      overrun_q <= 1'b0;
      busy_q    <= 1'b0;
      valid_q   <= 1'b0;
      ack_q     <= 1'b0;
      data_q    <= '0;
    end else begin
      state_q   <= state_d;
      timer_q   <= timer_d;
      idx_q     <= idx_d;
      snap_q    <= snap_d;
      prev_q    <= prev_d;
      vsh_q     <= vsh_d;
      pos_q     <= pos_d;
      vel_q     <= vel_d;
      seq_q     <= seq_d;
      primed_q  <= primed_d;
      overrun_q <= overrun_d;
      busy_q    <= busy_d;
      valid_q   <= valid_d;
      ack_q     <= ack_d;
      data_q    <= data_d;
    end
  end

  assign rd_ack       = ack_q;
  assign rd_data      = data_q;
  assign sample_valid = valid_q;
  assign busy         = busy_q;
endmodule

// File: tb/tb_enc_sampler.sv
// tb_enc_sampler: directed + randomized checks of enc_sampler
// against a register-level reference model of published sets.
module tb_enc_sampler;
  localparam int NCH    = 4;
  localparam int PERIOD = 64;

  logic              clk = 1'b0;
  logic              rst;
  logic [NCH*32-1:0] enc_count;
  logic              sample_now;
  logic              rd_req;
  logic [3:0]        rd_addr;
  logic              rd_ack;
  logic [31:0]       rd_data;
  logic              sample_valid;
  logic              busy;

  logic [31:0] cur [NCH];
  assign enc_count = {cur[3], cur[2], cur[1], cur[0]};

  enc_sampler #(.NCH(NCH), .PERIOD(PERIOD)) dut (
    .clk(clk), .rst(rst), .enc_count(enc_count),
    .sample_now(sample_now), .rd_req(rd_req), .rd_addr(rd_addr),
    .rd_ack(rd_ack), .rd_data(rd_data),
    .sample_valid(sample_valid), .busy(busy)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  logic [31:0] m_pos  [NCH];
  logic [31:0] m_vel  [NCH];
  logic [31:0] m_prev [NCH];
  int unsigned m_seq;
  bit          m_primed;
  bit          m_ovr;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: got %08h want %08h", tag, obs, exp);
    end
  endtask

  task automatic reset_model();
    for (int i = 0; i < NCH; i++) begin
      m_pos[i]  = '0;
      m_vel[i]  = '0;
      m_prev[i] = '0;
    end
    m_seq    = 0;
    m_primed = 1'b0;
    m_ovr    = 1'b0;
  endtask

  // one complete sample of the currently held counts
  task automatic apply_sample();
    for (int i = 0; i < NCH; i++) begin
      m_vel[i]  = m_primed ? cur[i] - m_prev[i] : 32'd0;
      m_prev[i] = cur[i];
      m_pos[i]  = cur[i];
    end
    m_seq    = m_seq + 1;
    m_primed = 1'b1;
  endtask

  function automatic logic [31:0] expect_rd(input logic [3:0] a);
    if (a < 4) return m_pos[a[1:0]];
    if (a >= 8 && a < 12) return m_vel[a[1:0]];
    if (a == 4'hF)
      return {m_ovr, 1'b0, m_primed, 13'b0, m_seq[15:0]};
    return 32'd0;
  endfunction

  task automatic do_read(input logic [3:0] a, output logic [31:0] d);
    bit got;
    got = 1'b0;
    d   = '0;
    @(negedge clk);
    rd_req  = 1'b1;
    rd_addr = a;
    for (int i = 0; i < 4 && !got; i++) begin
      @(negedge clk);
      if (rd_ack) begin
        got = 1'b1;
        d   = rd_data;
      end
    end
    rd_req = 1'b0;
    tests++;
    assert (got) else begin
      fails++;
      $error("FAIL rd_timeout: got no ack want ack (addr %0d)", a);
    end
  endtask

  task automatic check_read(input logic [3:0] a, input string tag);
    logic [31:0] d;
    do_read(a, d);
    chk($sformatf("%s@%0d", tag, a), d, expect_rd(a));
    if (a == 4'hF) m_ovr = 1'b0;
  endtask

  task automatic check_all(input string tag);
    for (int a = 0; a < 16; a++) check_read(4'(a), tag);
  endtask

  task automatic wait_valid(input string tag);
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < 200 && !seen; i++) begin
      @(negedge clk);
      if (sample_valid) seen = 1'b1;
    end
    tests++;
    assert (seen) else begin
      fails++;
      $error("FAIL %s_timeout: got no sample_valid want pulse", tag);
    end
    if (seen) apply_sample();
  endtask

  task automatic check_zero(input string tag);
    chk({tag, "_ack"},   32'(rd_ack),       32'd0);
    chk({tag, "_data"},  rd_data,           32'd0);
    chk({tag, "_valid"}, 32'(sample_valid), 32'd0);
    chk({tag, "_busy"},  32'(busy),         32'd0);
  endtask

  task automatic bump_counts();
    for (int i = 0; i < NCH; i++)
      cur[i] = cur[i] + 32'($urandom_range(1, 500));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] d;
    int          bc, vk, vc;
    logic        ack_obs;
    logic [31:0] dat_obs;

    rst        = 1'b1;
    sample_now = 1'b0;
    rd_req     = 1'b0;
    rd_addr    = '0;
    for (int i = 0; i < NCH; i++) cur[i] = '0;
    reset_model();
    repeat (2) @(negedge clk);
    check_zero("reset");
    rst = 1'b0;
    check_read(4'hF, "status0");

    cur[0] = 32'd10; cur[1] = 32'd20;
    cur[2] = 32'd30; cur[3] = 32'd40;
    wait_valid("s1");
    check_all("s1");

    cur[0] = 32'd15; cur[1] = 32'd20;
    cur[2] = 32'd25; cur[3] = 32'hFFFF_FFF0;
    wait_valid("s2");
    check_all("s2");
    do_read(4'd8, d);
    chk("s2_vel0_lit", d, 32'd5);
    do_read(4'd10, d);
    chk("s2_vel2_lit", d, 32'hFFFF_FFFB);

    cur[0] = 32'hFFFF_FFFE;
    wait_valid("w1");
    cur[0] = 32'd3;
    wait_valid("w2");
    do_read(4'd8, d);
    chk("wrap_vel_lit", d, 32'd5);
    check_read(4'd8, "wrap");

    repeat (4) begin
      for (int i = 0; i < NCH; i++)
        cur[i] = cur[i] + 32'($urandom_range(0, 4000)) - 32'd2000;
      wait_valid("rnd");
      check_all("rnd");
    end

    // sample_now: busy width, publish latency, coherent read
    wait_valid("pre_sn");
    bump_counts();
    bc = 0; vk = 0;
    ack_obs = 1'b0; dat_obs = '0;
    @(negedge clk);
    sample_now = 1'b1;
    for (int k = 1; k <= 12; k++) begin
      @(negedge clk);
      if (k == 1) sample_now = 1'b0;
      if (busy) bc++;
      if (sample_valid && vk == 0) vk = k;
      if (k == 5) begin
        rd_req  = 1'b1;
        rd_addr = 4'd0;
      end
      if (k == 6) begin
        ack_obs = rd_ack;
        dat_obs = rd_data;
        rd_req  = 1'b0;
      end
    end
    chk("sn_busy_cycles", 32'(bc), 32'd5);
    chk("sn_valid_edge", 32'(vk), 32'd6);
    chk("pub_edge_ack", 32'(ack_obs), 32'd1);
    chk("pub_edge_old", dat_obs, m_pos[0]);
    apply_sample();
    check_read(4'd0, "pub_new");
    check_read(4'hF, "sn_status");

    // trigger during SCAN is dropped and flagged
    wait_valid("pre_ov");
    bump_counts();
    vc = 0;
    @(negedge clk);
    sample_now = 1'b1;
    for (int k = 1; k <= 20; k++) begin
      @(negedge clk);
      if (k == 1) sample_now = 1'b0;
      if (k == 2) sample_now = 1'b1;
      if (k == 3) sample_now = 1'b0;
      if (sample_valid) vc++;
    end
    chk("ov_one_sample", 32'(vc), 32'd1);
    apply_sample();
    m_ovr = 1'b1;
    check_read(4'hF, "ov_status1");
    check_read(4'hF, "ov_status2");
    check_read(4'd1, "ov_pos");

    // reset in the middle of SCAN
    wait_valid("pre_rst");
    bump_counts();
    do_read(4'd0, d);
    @(negedge clk);
    sample_now = 1'b1;
    @(negedge clk);
    sample_now = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    #1;
    check_zero("async_rst");
    @(negedge clk);
    rst = 1'b0;
    reset_model();
    wait_valid("post_rst");
    check_read(4'hF, "rst_status");
    for (int a = 8; a < 12; a++) check_read(4'(a), "rst_vel");
    check_read(4'd5, "rst_addr5");
    check_read(4'd0, "rst_pos");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
